// File: rtl/cgra_exec_ctrl.sv
// cgra_exec_ctrl: execution sequencer for the 6x6 torus PE array.
// Turns a Computation_Start rising edge into a run of Inst_Num instructions
// repeated Iter_Num times. It then waits Drain_Cycles for the array pipeline
// to empty and raises Computation_Done until the host drops Start.
// Every output is registered, so no combinational path runs from inputs to outputs.
module cgra_exec_ctrl #(
    parameter int IADDR_WIDTH = 8,
    parameter int DADDR_WIDTH = 12,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   Computation_Start,
    input  logic [IADDR_WIDTH-1:0] Inst_Num,
    input  logic [CNT_WIDTH-1:0]   Iter_Num,
    input  logic [3:0]             Drain_Cycles,
    input  logic [DADDR_WIDTH-1:0] Load_Base,
    input  logic [DADDR_WIDTH-1:0] Store_Base,
    input  logic [DADDR_WIDTH-1:0] Load_Stride,
    input  logic [DADDR_WIDTH-1:0] Store_Stride,
    output logic [IADDR_WIDTH-1:0] Inst_Addr,
    output logic                   Inst_Valid,
    output logic [CNT_WIDTH-1:0]   Iter_Index,
    output logic [DADDR_WIDTH-1:0] Load_Addr,
    output logic [DADDR_WIDTH-1:0] Store_Addr,
    output logic                   PE_Array_Busy,
    output logic                   Computation_Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_reg;
    logic                   start_q_reg;
    logic [IADDR_WIDTH-1:0] inst_num_reg;
    logic [CNT_WIDTH-1:0]   iter_num_reg;
    logic [3:0]             drain_cfg_reg;
    logic [3:0]             drain_cnt_reg;
    logic [DADDR_WIDTH-1:0] load_stride_reg;
    logic [DADDR_WIDTH-1:0] store_stride_reg;

    logic start_edge;
    logic last_inst;
    logic last_iter;

    // A start is a rising edge of the host level. start_q resets to 0, so a
    // Start that is already high when reset releases also counts as an edge.
    assign start_edge = Computation_Start & ~start_q_reg;
    // These terms use latched config, so they are only meaningful in RUN,
    // where both counts are known to be non-zero.
    assign last_inst  = (Inst_Addr == inst_num_reg - IADDR_WIDTH'(1));
    assign last_iter  = (Iter_Index == iter_num_reg - CNT_WIDTH'(1));

    // Sequencer FSM. It also owns all registered outputs and the latched configuration.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_reg        <= S_IDLE;
            start_q_reg      <= 1'b0;
            inst_num_reg     <= '0;
            iter_num_reg     <= '0;
            drain_cfg_reg    <= '0;
            drain_cnt_reg    <= '0;
            load_stride_reg  <= '0;
            store_stride_reg <= '0;
            Inst_Addr        <= '0;
            Inst_Valid       <= 1'b0;
            Iter_Index       <= '0;
            Load_Addr        <= '0;
            Store_Addr       <= '0;
            PE_Array_Busy    <= 1'b0;
            Computation_Done <= 1'b0;
        end else begin
            start_q_reg <= Computation_Start;
            case (state_reg)
                S_IDLE: begin
                    if (start_edge) begin
                        // Snapshot the config. The host may rewrite it while the run is in flight.
                        inst_num_reg     <= Inst_Num;
                        iter_num_reg     <= Iter_Num;
                        drain_cfg_reg    <= Drain_Cycles;
                        load_stride_reg  <= Load_Stride;
                        store_stride_reg <= Store_Stride;
                        Inst_Addr        <= '0;
                        Iter_Index       <= '0;
                        Load_Addr        <= Load_Base;
                        Store_Addr       <= Store_Base;
                        if (Inst_Num == '0 || Iter_Num == '0) begin
                            // An empty kernel completes at once and never shows busy.
                            state_reg        <= S_DONE;
                            Computation_Done <= 1'b1;
                        end else begin
                            state_reg     <= S_RUN;
                            Inst_Valid    <= 1'b1;
                            PE_Array_Busy <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (last_inst) begin
                        if (last_iter) begin
                            // Final instruction issued. The address and index
                            // outputs keep their last values.
                            Inst_Valid <= 1'b0;
                            if (drain_cfg_reg == 4'd0) begin
                                state_reg        <= S_DONE;
                                PE_Array_Busy    <= 1'b0;
                                Computation_Done <= 1'b1;
                            end else begin
                                state_reg     <= S_DRAIN;
                                drain_cnt_reg <= drain_cfg_reg;
                            end
                        end else begin
                            // Iteration wrap. Data bases advance modulo the BRAM size.
                            Inst_Addr  <= '0;
                            Iter_Index <= Iter_Index + CNT_WIDTH'(1);
                            Load_Addr  <= Load_Addr + load_stride_reg;
                            Store_Addr <= Store_Addr + store_stride_reg;
                        end
                    end else begin
                        Inst_Addr <= Inst_Addr + IADDR_WIDTH'(1);
                    end
                end

                S_DRAIN: begin
                    // A load of N gives exactly N drain cycles.
                    if (drain_cnt_reg == 4'd1) begin
                        state_reg        <= S_DONE;
                        PE_Array_Busy    <= 1'b0;
                        Computation_Done <= 1'b1;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg - 4'd1;
                    end
                end

                S_DONE: begin
                    // Done stays up until the host releases Start.
                    if (!Computation_Start) begin
                        state_reg        <= S_IDLE;
                        Computation_Done <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Testbench for cgra_exec_ctrl. Runs a table of directed kernel configs with
// hand-computed results, checks every cycle against the expected address walk,
// and adds hand-written sequences for reset, protocol abuse and reset mid-run.
module tb_cgra_exec_ctrl;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  inst_num;
    logic [15:0] iter_num;
    logic [3:0]  drain_cycles;
    logic [11:0] load_base, store_base, load_stride, store_stride;
    logic [7:0]  inst_addr;
    logic        inst_valid;
    logic [15:0] iter_index;
    logic [11:0] load_addr, store_addr;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  inst;
        logic [15:0] iter;
        logic [3:0]  drain;
        logic [11:0] lb, ls, sb, ss;
        int          exp_busy;
        logic [7:0]  exp_addr;
        logic [15:0] exp_iter;
        logic [11:0] exp_load, exp_store;
    } vec_t;

    vec_t vecs[5];

    cgra_exec_ctrl #(.IADDR_WIDTH(8), .DADDR_WIDTH(12), .CNT_WIDTH(16)) dut (
        .Clk(clk),
        .Resetn(resetn),
        .Computation_Start(start),
        .Inst_Num(inst_num),
        .Iter_Num(iter_num),
        .Drain_Cycles(drain_cycles),
        .Load_Base(load_base),
        .Store_Base(store_base),
        .Load_Stride(load_stride),
        .Store_Stride(store_stride),
        .Inst_Addr(inst_addr),
        .Inst_Valid(inst_valid),
        .Iter_Index(iter_index),
        .Load_Addr(load_addr),
        .Store_Addr(store_addr),
        .PE_Array_Busy(busy),
        .Computation_Done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {13'd0, inst_valid, busy, done, inst_addr, iter_index, load_addr, store_addr};
    endfunction

    // Run one table entry. Each cycle is checked against the expected walk:
    // cycle k of RUN issues instruction k%inst of iteration k/inst.
    task automatic run_cfg(input int idx, input bit abuse, input bit prestarted);
        vec_t v;
        int k, r, j;
        bit got_done;
        logic [11:0] el, es;
        logic [7:0]  ea;
        logic [15:0] ei;
        logic        ev;
        v = vecs[idx];
        inst_num = v.inst; iter_num = v.iter; drain_cycles = v.drain;
        load_base = v.lb; load_stride = v.ls; store_base = v.sb; store_stride = v.ss;
        if (!prestarted) start = 1'b1;
        r = int'(v.inst) * int'(v.iter);
        k = 0;
        got_done = 1'b0;
        while (k <= v.exp_busy + 4) begin
            @(posedge clk); #1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (v.inst == 0 || v.iter == 0) begin
                check($sformatf("cfg%0d empty_no_busy", idx), outs(), 64'hFFFF);
            end else begin
                if (k < r) begin
                    j = k / int'(v.inst); ea = 8'(k % int'(v.inst)); ev = 1'b1;
                end else begin
                    j = int'(v.iter) - 1; ea = v.inst - 8'd1; ev = 1'b0;
                end
                ei = 16'(j);
                el = 12'(int'(v.lb) + int'(v.ls) * j);
                es = 12'(int'(v.sb) + int'(v.ss) * j);
                check($sformatf("cfg%0d trace_k%0d", idx, k), outs(),
                      {13'd0, ev, 1'b1, 1'b0, ea, ei, el, es});
            end
            if (abuse && k == 3) begin
                start = 1'b0; inst_num = 8'd2; iter_num = 16'd7; drain_cycles = 4'd9;
                load_base = 12'hABC; load_stride = 12'h333; store_base = 12'h123; store_stride = 12'h777;
            end
            if (abuse && k == 6) start = 1'b1;
            k++;
        end
        check($sformatf("cfg%0d done_seen", idx), 64'(got_done), 64'd1);
        check($sformatf("cfg%0d busy_cycles", idx), 64'(k), 64'(v.exp_busy));
        check($sformatf("cfg%0d done_state", idx), outs(),
              {13'd0, 1'b0, 1'b0, 1'b1, v.exp_addr, v.exp_iter, v.exp_load, v.exp_store});
        // Done must hold while Start stays high and fall one edge after Start drops.
        start = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("cfg%0d done_hold%0d", idx, c), {62'd0, done, busy}, 64'b10);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check($sformatf("cfg%0d done_fall", idx), {62'd0, done, busy}, 64'b00);
        $display("run cfg%0d abuse=%0d busy=%0d total=%0d bad=%0d", idx, abuse, k, total, bad);
    endtask

    initial begin
        //          inst   iter    drn   lb       ls       sb       ss       busy addr   iter    load     store
        vecs[0] = '{8'd4, 16'd3, 4'd2, 12'h100, 12'h010, 12'h200, 12'h008, 14, 8'd3, 16'd2, 12'h120, 12'h210};
        vecs[1] = '{8'd4, 16'd0, 4'd2, 12'h100, 12'h010, 12'h200, 12'h008, 0,  8'd0, 16'd0, 12'h100, 12'h200};
        vecs[2] = '{8'd0, 16'd3, 4'd2, 12'h040, 12'h010, 12'h050, 12'h008, 0,  8'd0, 16'd0, 12'h040, 12'h050};
        vecs[3] = '{8'd1, 16'd5, 4'd0, 12'hFF8, 12'h004, 12'h010, 12'h001, 5,  8'd0, 16'd4, 12'h008, 12'h014};
        vecs[4] = '{8'd3, 16'd2, 4'd15, 12'h7F0, 12'h008, 12'hFFE, 12'h003, 21, 8'd2, 16'd1, 12'h7F8, 12'h001};

        resetn = 1'b0; start = 1'b0;
        inst_num = '0; iter_num = '0; drain_cycles = '0;
        load_base = '0; load_stride = '0; store_base = '0; store_stride = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 64'd0);
        @(negedge clk) resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check($sformatf("idle_c%0d", c), outs(), 64'd0);
        end

        for (int i = 0; i < 5; i++) run_cfg(i, 1'b0, 1'b0);

        // Config rewrites and a Start toggle mid-run must not disturb the basic trace.
        run_cfg(0, 1'b1, 1'b0);

        // Reset asserted during DRAIN: outputs clear asynchronously.
        inst_num = 8'd4; iter_num = 16'd3; drain_cycles = 4'd2;
        load_base = 12'h100; load_stride = 12'h010; store_base = 12'h200; store_stride = 12'h008;
        start = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_in_drain", {62'd0, busy, inst_valid}, 64'b10);
        #2 resetn = 1'b0;
        #1;
        check("reset_mid_drain", outs(), 64'd0);
        // Start is held high through reset release, which counts as a fresh edge.
        start = 1'b1;
        @(negedge clk) resetn = 1'b1;
        run_cfg(0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
